// File: rtl/booth_mul_256x64.sv
// Sequential unsigned radix-4 Booth multiplier: 256-bit A x 64-bit B -> 320-bit P.
// One Booth digit is retired per clock; a start/done handshake frames each
// operation (IDLE -> CALC for 33 digits -> DONE for one cycle -> IDLE).
module booth_mul_256x64 #(
  parameter int WA = 256,
  parameter int WB = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WA-1:0]    A,
  input  logic [WB-1:0]    B,
  output logic [WA+WB-1:0] P,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = (WB + 2) / 2;        // Booth digits, top one always >= 0
  localparam int CW   = $clog2(NDIG);        // digit counter width
  localparam int BW   = WB + 3;              // 2 zero-extension bits + B + implicit b[-1]
  localparam int PPW  = WA + 2;              // room for +/-2A in two's complement
  localparam int ACCW = WA + WB + 2;         // signed accumulator width

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WA-1:0]     a_q;
  logic [BW-1:0]     b_q;          // shifted right 2 per digit; [2:0] is the current triplet
  logic [CW-1:0]     cnt_q;
  logic [ACCW-1:0]   acc_q;
  logic [WA+WB-1:0]  p_q;

  logic              last_digit;
  logic [PPW-1:0]    pp;
  logic [ACCW-1:0]   pp_ext;
  logic [ACCW-1:0]   addend;
  logic [ACCW-1:0]   acc_sum;

  assign last_digit = (cnt_q == CW'(NDIG - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Booth digit decode of the current triplet into a signed partial product.
  always_comb begin
    pp = '0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = {2'b00, a_q};
      3'b011:         pp = {1'b0, a_q, 1'b0};
      3'b100:         pp = -{1'b0, a_q, 1'b0};
      3'b101, 3'b110: pp = -{2'b00, a_q};
      default:        pp = '0;
    endcase
  end

  // Sign-extend the partial product and align it to digit position 2*cnt.
  always_comb begin
    pp_ext  = {{(ACCW - PPW){pp[PPW-1]}}, pp};
    addend  = pp_ext << {cnt_q, 1'b0};
    acc_sum = acc_q + addend;
  end

  // Operand capture, accumulation and result register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are plain flops, not a memory array, so all of them are
    // reset; an abort leaves no stale operand or partial sum behind.
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      p_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= {2'b00, B, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_sum;
          b_q   <= b_q >> 2;
          cnt_q <= cnt_q + CW'(1);
          // Final accumulator is non-negative; the two guard bits are always 0.
          if (last_digit) p_q <= acc_sum[WA+WB-1:0];
        end
        default: ;
      endcase
    end
  end

  assign P    = p_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_booth_mul_256x64.sv
// Directed self-checking bench for booth_mul_256x64. Edges are numbered with
// the start-accepting edge as edge 1, so a result shows done after edge 34.
module tb_booth_mul_256x64;

  localparam int WA = 256;
  localparam int WB = 64;
  localparam int PW = WA + WB;
  localparam int LAT = 34;     // edges from accept (edge 1) to done
  localparam int BOUND = 100;  // wait budget in edges

  logic          clk;
  logic          rst;
  logic          start;
  logic [WA-1:0] A;
  logic [WB-1:0] B;
  logic [PW-1:0] P;
  logic          busy;
  logic          done;

  int vectors;
  int miscompares;

  booth_mul_256x64 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for IDLE, issues one operation and returns the edge on which done
  // was observed (accepting edge = 1); returns BOUND on timeout.
  task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (lat < BOUND) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #12;
    vectors++;
    if (P !== '0) begin miscompares++; $display("FAIL reset_p: got %h want 0", P); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    do_op(256'd475, 64'd422, lat);
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    vectors++;
    if (P !== 320'h30F02) begin miscompares++; $display("FAIL basic_p: got %h want 30f02", P); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    vectors++;
    if (P !== 320'h30F02) begin miscompares++; $display("FAIL basic_p_hold: got %h want 30f02", P); end
  endtask

  task automatic test_zero();
    int lat;
    do_op('1, 64'd0, lat);
    vectors++;
    if (P !== '0) begin miscompares++; $display("FAIL zero_b: got %h want 0", P); end
    do_op(256'd0, 64'd12345, lat);
    vectors++;
    if (P !== '0) begin miscompares++; $display("FAIL zero_a: got %h want 0", P); end
  endtask

  task automatic test_max();
    int lat;
    logic [PW-1:0] exp_p;
    // (2^64-1)(2^256-1) = 2^320 - 2^256 - 2^64 + 1
    exp_p = {64'hFFFF_FFFF_FFFF_FFFE, {192{1'b1}}, 64'h0000_0000_0000_0001};
    do_op('1, '1, lat);
    vectors++;
    if (P !== exp_p) begin miscompares++; $display("FAIL max: got %h want %h", P, exp_p); end
  endtask

  task automatic test_sign_runs();
    int lat;
    logic [WA-1:0] a_top;
    logic [PW-1:0] exp_p;
    do_op(256'd1, '1, lat);
    exp_p = {256'd0, {64{1'b1}}};
    vectors++;
    if (P !== exp_p) begin miscompares++; $display("FAIL ones_b: got %h want %h", P, exp_p); end
    a_top = '0;
    a_top[WA-1] = 1'b1;
    do_op(a_top, 64'd2, lat);
    exp_p = '0;
    exp_p[256] = 1'b1;
    vectors++;
    if (P !== exp_p) begin miscompares++; $display("FAIL top_a: got %h want %h", P, exp_p); end
  endtask

  // Start ignored while busy, inputs changed mid-run, then a back-to-back op.
  task automatic test_back_to_back();
    int e;
    int w;
    logic accepted;
    w = 0;
    @(negedge clk);
    while (busy && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    A = 256'd3;
    B = 64'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = 1;
    while (e < BOUND) begin
      @(negedge clk);
      if (done) break;
      if (e == 10) begin
        start = 1'b1;
        A = 256'd7;
        B = 64'd7;
      end else if (e == 11) begin
        start = 1'b0;
        A = 256'd9;
        B = 64'd11;
      end
      @(posedge clk);
      e++;
    end
    vectors++;
    if (e !== LAT) begin miscompares++; $display("FAIL ignore_latency: got %0d want %0d", e, LAT); end
    vectors++;
    if (P !== 320'd15) begin miscompares++; $display("FAIL ignore_p: got %h want f", P); end
    // Hold start from the done cycle; it is taken at the first IDLE edge.
    A = 256'd7;
    B = 64'd7;
    start = 1'b1;
    accepted = 1'b0;
    while (e < 2 * BOUND) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (!accepted && busy && !done) begin
        accepted = 1'b1;
        start = 1'b0;
        A = 256'd2;
        B = 64'd3;
      end
      if (accepted && done) break;
    end
    start = 1'b0;
    vectors++;
    if (e !== 69) begin miscompares++; $display("FAIL b2b_latency: got %0d want 69", e); end
    vectors++;
    if (P !== 320'd49) begin miscompares++; $display("FAIL b2b_p: got %h want 31", P); end
  endtask

  task automatic test_reset_abort();
    int e;
    int lat;
    @(negedge clk);
    while (busy) @(negedge clk);
    A = 256'd1000;
    B = 64'd1000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (e = 1; e < 20; e++) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (P !== '0) begin miscompares++; $display("FAIL abort_p: got %h want 0", P); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", done); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    do_op(256'd475, 64'd422, lat);
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL abort_rerun_latency: got %0d want %0d", lat, LAT); end
    vectors++;
    if (P !== 320'h30F02) begin miscompares++; $display("FAIL abort_rerun_p: got %h want 30f02", P); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_sign_runs();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
